// File: rtl/flash_cmd_sequencer_if.sv
// Command hand-over and flash bus signals between the CPU-side decode and the
// flash command sequencer.
interface flash_cmd_sequencer_if;
    logic        cmd_start;
    logic        cmd_erase;
    logic [26:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic [7:0]  flash_dq_in;
    logic        seq_active;
    logic [26:0] seq_addr;
    logic [7:0]  seq_data;
    logic        seq_data_oe;
    logic        seq_ce_n;
    logic        seq_oe_n;
    logic        seq_we_n;
    logic        busy;
    logic        done;
    logic        fail;

    modport master (
        output cmd_start, cmd_erase, cmd_addr, cmd_data, flash_dq_in,
        input  seq_active, seq_addr, seq_data, seq_data_oe, seq_ce_n,
               seq_oe_n, seq_we_n, busy, done, fail
    );

    modport slave (
        input  cmd_start, cmd_erase, cmd_addr, cmd_data, flash_dq_in,
        output seq_active, seq_addr, seq_data, seq_data_oe, seq_ce_n,
               seq_oe_n, seq_we_n, busy, done, fail
    );
endinterface

// File: rtl/flash_cmd_sequencer.sv
// JEDEC byte-program / sector-erase sequencer: issues the unlock and command
// bus writes, DQ7-polls for completion, verifies, and aborts on timeout.
module flash_cmd_sequencer #(
    parameter logic [11:0] UNLOCK_ADDR1  = 12'hAAA,
    parameter logic [11:0] UNLOCK_ADDR2  = 12'h555,
    parameter int unsigned PROG_TIMEOUT  = 1024,
    parameter int unsigned ERASE_TIMEOUT = 2097152,
    parameter int unsigned TMR_BITS      = 22
) (
    input logic                  m2,
    input logic                  reset_n,
    flash_cmd_sequencer_if.slave ctl
);

    localparam int unsigned AW   = 27;
    localparam int unsigned DW   = 8;
    localparam int unsigned SW   = 3;
    localparam int unsigned HI_W = AW - 12;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_SETUP,
        S_W_PULSE,
        S_W_HOLD,
        S_POLL,
        S_VERIFY,
        S_A_SETUP,
        S_A_PULSE,
        S_A_HOLD,
        S_FIN_OK,
        S_FIN_ERR
    } state_e;

    state_e                state_q, state_d;
    logic [SW-1:0]         step_q, step_d;
    logic                  erase_q, erase_d;
    logic [AW-1:0]         caddr_q, caddr_d;
    logic [DW-1:0]         cdata_q, cdata_d;
    logic [TMR_BITS-1:0]   tmr_q, tmr_d;
    logic                  match_q, match_d;
    logic                  active_q, active_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fail_q, fail_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DW-1:0]         wdata_q, wdata_d;
    logic                  data_oe_q, data_oe_d;
    logic                  ce_n_q, ce_n_d;
    logic                  oe_n_q, oe_n_d;
    logic                  we_n_q, we_n_d;

    logic [TMR_BITS-1:0]   tmr_lim;
    logic [SW-1:0]         last_step;
    logic                  dq7_ok;
    logic [HI_W-1:0]       hi;
    logic [AW-1:0]         wr_addr;
    logic [DW-1:0]         wr_data;

    assign tmr_lim   = erase_q ? TMR_BITS'(ERASE_TIMEOUT) : TMR_BITS'(PROG_TIMEOUT);
    assign last_step = erase_q ? SW'(5) : SW'(3);
    assign dq7_ok    = (ctl.flash_dq_in[7] == (erase_q ? 1'b1 : cdata_q[7]));

    // Next state, then registered bus/flag values decoded from the state being entered
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        erase_d = erase_q;
        caddr_d = caddr_q;
        cdata_d = cdata_q;
        tmr_d   = tmr_q;
        match_d = match_q;
        done_d  = done_q;
        fail_d  = fail_q;
        hi      = '0;
        wr_addr = '0;
        wr_data = '0;

        case (state_q)
            S_IDLE: begin
                if (ctl.cmd_start) begin
                    erase_d = ctl.cmd_erase;
                    caddr_d = ctl.cmd_addr;
                    cdata_d = ctl.cmd_data;
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                    step_d  = '0;
                    state_d = S_W_SETUP;
                end
            end
            S_W_SETUP: state_d = S_W_PULSE;
            S_W_PULSE: state_d = S_W_HOLD;
            S_W_HOLD: begin
                if (step_q == last_step) begin
                    tmr_d   = '0;
                    match_d = 1'b0;
                    state_d = S_POLL;
                end else begin
                    step_d  = step_q + SW'(1);
                    state_d = S_W_SETUP;
                end
            end
            S_POLL: begin
                // Two back-to-back DQ7 matches win over a timeout on the same cycle
                if (dq7_ok && match_q) begin
                    state_d = S_VERIFY;
                end else begin
                    match_d = dq7_ok;
                    if (tmr_q < tmr_lim) tmr_d = tmr_q + TMR_BITS'(1);
                    if (tmr_q >= tmr_lim - TMR_BITS'(1)) state_d = S_A_SETUP;
                end
            end
            S_VERIFY: begin
                if (ctl.flash_dq_in == (erase_q ? DW'(8'hFF) : cdata_q)) state_d = S_FIN_OK;
                else                                                       state_d = S_FIN_ERR;
            end
            S_A_SETUP: state_d = S_A_PULSE;
            S_A_PULSE: state_d = S_A_HOLD;
            S_A_HOLD:  state_d = S_FIN_ERR;
            S_FIN_OK:  state_d = S_IDLE;
            S_FIN_ERR: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (state_d == S_FIN_OK)  done_d = 1'b1;
        if (state_d == S_FIN_ERR) fail_d = 1'b1;

        // Unlock / command write table, indexed by the step being entered
        hi = caddr_d[AW-1:12];
        case (step_d)
            SW'(0):  begin wr_addr = {hi, UNLOCK_ADDR1}; wr_data = 8'hAA; end
            SW'(1):  begin wr_addr = {hi, UNLOCK_ADDR2}; wr_data = 8'h55; end
            SW'(2):  begin wr_addr = {hi, UNLOCK_ADDR1}; wr_data = erase_d ? 8'h80 : 8'hA0; end
            SW'(3):  begin
                if (erase_d) begin wr_addr = {hi, UNLOCK_ADDR1}; wr_data = 8'hAA;   end
                else         begin wr_addr = caddr_d;            wr_data = cdata_d; end
            end
            SW'(4):  begin wr_addr = {hi, UNLOCK_ADDR2}; wr_data = 8'h55; end
            default: begin wr_addr = {hi, 12'h000};      wr_data = 8'h30; end
        endcase

        active_d  = (state_d != S_IDLE);
        busy_d    = (state_d != S_IDLE);
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        data_oe_d = 1'b0;
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;

        case (state_d)
            S_W_SETUP, S_W_PULSE, S_W_HOLD: begin
                addr_d    = wr_addr;
                wdata_d   = wr_data;
                data_oe_d = 1'b1;
                ce_n_d    = 1'b0;
                we_n_d    = (state_d != S_W_PULSE);
            end
            S_POLL, S_VERIFY: begin
                addr_d = caddr_d;
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            S_A_SETUP, S_A_PULSE, S_A_HOLD: begin
                addr_d    = caddr_d;
                wdata_d   = 8'hF0;
                data_oe_d = 1'b1;
                ce_n_d    = 1'b0;
                we_n_d    = (state_d != S_A_PULSE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            erase_q   <= 1'b0;
            caddr_q   <= '0;
            cdata_q   <= '0;
            tmr_q     <= '0;
            match_q   <= 1'b0;
            active_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            data_oe_q <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            erase_q   <= erase_d;
            caddr_q   <= caddr_d;
            cdata_q   <= cdata_d;
            tmr_q     <= tmr_d;
            match_q   <= match_d;
            active_q  <= active_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            data_oe_q <= data_oe_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
        end
    end

    assign ctl.seq_active  = active_q;
    assign ctl.seq_addr    = addr_q;
    assign ctl.seq_data    = wdata_q;
    assign ctl.seq_data_oe = data_oe_q;
    assign ctl.seq_ce_n    = ce_n_q;
    assign ctl.seq_oe_n    = oe_n_q;
    assign ctl.seq_we_n    = we_n_q;
    assign ctl.busy        = busy_q;
    assign ctl.done        = done_q;
    assign ctl.fail        = fail_q;

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Scoreboard bench for flash_cmd_sequencer: a behavioural flash model answers
// polls, expected writes/outcomes are queued at issue time and popped by a monitor.
module tb_flash_cmd_sequencer;

    typedef struct packed {
        logic [26:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        bit done;
        bit fail;
        int polls;
    } res_t;

    logic m2 = 1'b0;
    logic reset_n;
    always #5 m2 = ~m2;

    flash_cmd_sequencer_if bus ();

    flash_cmd_sequencer dut (
        .m2      (m2),
        .reset_n (reset_n),
        .ctl     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    wr_t  exp_wr[$];
    res_t exp_res[$];

    // Flash model knobs, set by the stimulus before each command
    int          ready_after = -1;
    logic [7:0]  final_byte  = 8'h00;
    bit          exp7        = 1'b0;
    logic [26:0] cur_addr    = '0;
    int          poll_cnt    = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Flash model: DQ7 inverted while busy, final byte once the operation completes
    always @(negedge m2) begin
        if (!bus.seq_active)     poll_cnt = 0;
        else if (!bus.seq_oe_n)  poll_cnt++;
        if (ready_after >= 0 && poll_cnt > ready_after) bus.flash_dq_in = final_byte;
        else                                            bus.flash_dq_in = {~exp7, 7'h2A};
    end

    // Monitor: bus writes, poll bus state, bus release ordering and completion flags
    int       low_cnt = 0;
    int       polls   = 0;
    wr_t      cap;
    logic     prev_active = 1'b0;
    logic     prev_busy   = 1'b0;
    logic [3:0] prev_strb = 4'b1110;

    always @(negedge m2) begin
        if (reset_n === 1'b1) begin
            if (!bus.seq_we_n) begin
                low_cnt++;
                cap = '{addr: bus.seq_addr, data: bus.seq_data};
                chk("pulse_drive", {bus.seq_data_oe, bus.seq_ce_n, bus.seq_oe_n}, 3'b101);
            end else if (low_cnt > 0) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", {cap.addr, cap.data}, 35'h0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("write_addr", cap.addr, e.addr);
                    chk("write_data", cap.data, e.data);
                end
                chk("we_low_cycles", low_cnt, 1);
                low_cnt = 0;
            end
            if (!bus.seq_oe_n) begin
                polls++;
                chk("poll_bus", {bus.seq_addr, bus.seq_data_oe, bus.seq_we_n}, {cur_addr, 1'b0, 1'b1});
            end
            if (prev_active && !bus.seq_active)
                chk("release_after_strobes", prev_strb, 4'b1110);
            if (prev_busy && !bus.busy) begin
                if (exp_res.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    res_t r;
                    r = exp_res.pop_front();
                    chk("done_flag", bus.done, r.done);
                    chk("fail_flag", bus.fail, r.fail);
                    chk("poll_cycles", polls, r.polls);
                    chk("writes_drained", exp_wr.size(), 0);
                end
            end
            if (!bus.busy) polls = 0;
        end else begin
            low_cnt = 0;
            polls   = 0;
        end
        prev_active = bus.seq_active;
        prev_busy   = bus.busy;
        prev_strb   = {bus.seq_ce_n, bus.seq_oe_n, bus.seq_we_n, bus.seq_data_oe};
    end

    // Expected writes and outcome straight from the JEDEC command rules
    task automatic push_expect(bit erase, logic [26:0] a, logic [7:0] d, int ready, logic [7:0] fin);
        logic [14:0] hi;
        res_t r;
        hi = a[26:12];
        exp_wr.push_back('{addr: {hi, 12'hAAA}, data: 8'hAA});
        exp_wr.push_back('{addr: {hi, 12'h555}, data: 8'h55});
        if (!erase) begin
            exp_wr.push_back('{addr: {hi, 12'hAAA}, data: 8'hA0});
            exp_wr.push_back('{addr: a, data: d});
        end else begin
            exp_wr.push_back('{addr: {hi, 12'hAAA}, data: 8'h80});
            exp_wr.push_back('{addr: {hi, 12'hAAA}, data: 8'hAA});
            exp_wr.push_back('{addr: {hi, 12'h555}, data: 8'h55});
            exp_wr.push_back('{addr: {hi, 12'h000}, data: 8'h30});
        end
        if (ready < 0) begin
            exp_wr.push_back('{addr: a, data: 8'hF0});
            r = '{done: 1'b0, fail: 1'b1, polls: 1024};
        end else begin
            r.done  = (fin == (erase ? 8'hFF : d));
            r.fail  = !r.done;
            r.polls = ready + 3;
        end
        exp_res.push_back(r);
    endtask

    task automatic issue(bit erase, logic [26:0] a, logic [7:0] d, int ready, logic [7:0] fin);
        push_expect(erase, a, d, ready, fin);
        ready_after = ready;
        final_byte  = fin;
        exp7        = erase ? 1'b1 : d[7];
        cur_addr    = a;
        @(negedge m2);
        bus.cmd_erase = erase;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        bus.cmd_start = 1'b1;
        @(negedge m2);
        bus.cmd_start = 1'b0;
        bus.cmd_erase = ~erase;
        bus.cmd_addr  = 27'($urandom);
        bus.cmd_data  = 8'($urandom);
    endtask

    task automatic wait_idle(int budget);
        int k = 0;
        while (bus.busy && k < budget) begin
            @(negedge m2);
            k++;
        end
        chk("cmd_complete_in_budget", bus.busy, 1'b0);
        repeat (3) @(negedge m2);
    endtask

    task automatic check_reset_outputs(string name);
        chk(name, {bus.seq_active, bus.busy, bus.done, bus.fail, bus.seq_data_oe,
                   bus.seq_ce_n, bus.seq_oe_n, bus.seq_we_n, bus.seq_addr, bus.seq_data},
                  {8'b0000_0111, 27'h0, 8'h00});
    endtask

    initial begin
        bit          er;
        logic [26:0] a;
        logic [7:0]  d, fin;
        int          rdy, kind;

        reset_n       = 1'b1;
        bus.cmd_start = 1'b0;
        bus.cmd_erase = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("reset_state");
        repeat (3) @(negedge m2);
        reset_n = 1'b1;
        @(negedge m2);
        check_reset_outputs("idle_after_reset");

        // Program that completes after 20 polls
        issue(1'b0, 27'h1234567, 8'h5A, 20, 8'h5A);
        wait_idle(3000);
        // Sector erase that completes after 500 polls
        issue(1'b1, 27'h0ABCDEF, 8'h00, 500, 8'hFF);
        wait_idle(3000);
        // Program that never completes: timeout, F0 reset write, fail
        issue(1'b0, 27'h1234567, 8'h3C, -1, 8'h00);
        wait_idle(3000);
        // DQ7 fine but read-back byte differs
        issue(1'b0, 27'h0000100, 8'h5A, 7, 8'h5B);
        wait_idle(3000);

        // cmd_start during step 1 write pulse must be ignored
        issue(1'b0, 27'h2F0F0F0, 8'hC3, 4, 8'hC3);
        repeat (4) @(posedge m2);
        #1;
        chk("ign_at_pulse", {bus.seq_we_n, bus.seq_addr[11:0]}, {1'b0, 12'h555});
        bus.cmd_start = 1'b1;
        bus.cmd_erase = 1'b1;
        bus.cmd_addr  = 27'h7FFFFFF;
        bus.cmd_data  = 8'h00;
        @(posedge m2);
        #1 bus.cmd_start = 1'b0;
        wait_idle(3000);

        // Asynchronous reset during step 2 write pulse
        issue(1'b0, 27'h3456789, 8'h81, 5, 8'h81);
        repeat (7) @(posedge m2);
        #1;
        chk("at_step2_pulse", {bus.seq_we_n, bus.seq_data}, {1'b0, 8'hA0});
        reset_n = 1'b0;
        #1;
        chk("reset_mid_cmd", {bus.seq_we_n, bus.seq_active, bus.busy}, 3'b100);
        check_reset_outputs("reset_mid_cmd_all");
        repeat (2) @(negedge m2);
        exp_wr.delete();
        exp_res.delete();
        reset_n = 1'b1;
        repeat (2) @(negedge m2);
        issue(1'b0, 27'h3456789, 8'h81, 5, 8'h81);
        wait_idle(3000);

        // Randomized commands
        for (int i = 0; i < 14; i++) begin
            er   = ($urandom_range(0, 3) == 0);
            a    = 27'($urandom);
            d    = 8'($urandom);
            rdy  = $urandom_range(0, 40);
            kind = $urandom_range(0, 5);
            fin  = er ? 8'hFF : d;
            if (kind == 0) fin = fin ^ {1'b0, 7'($urandom_range(1, 127))};
            if (kind == 1 && !er) rdy = -1;
            issue(er, a, d, rdy, fin);
            wait_idle(3000);
        end

        chk("scoreboard_empty", {32'(exp_wr.size()), 32'(exp_res.size())}, 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_cmd_sequencer.md
Name: flash_cmd_sequencer

Overview:
- Drives JEDEC byte-program and sector-erase command sequences into the multicart's parallel flash.
- CPU-side register decode hands over one command. The block takes over the flash address, data, CE, OE and WE lines, issues the unlock/command bus writes, then DQ7-polls for completion.
- Sits beside the mapper logic. While `seq_active` is high, the top-level flash muxes select this block's outputs over the normal cpu_addr_out/flash_* path.

Parameters:
- UNLOCK_ADDR1, 12'hAAA, low 12 bits of the first and third unlock address.
- UNLOCK_ADDR2, 12'h555, low 12 bits of the second unlock address.
- PROG_TIMEOUT, 1024, maximum poll cycles for a program command.
- ERASE_TIMEOUT, 2^21, maximum poll cycles for an erase command.
- TMR_BITS, 22, width of the poll timeout counter.

Ports:
- m2  input  1  CPU M2 clock; the only clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cmd_start  input  1  one-cycle request pulse.
- cmd_erase  input  1  sampled with cmd_start: 1 = sector erase, 0 = byte program.
- cmd_addr  input  27  target byte address (program) or any address inside the sector (erase).
- cmd_data  input  8  byte to program; ignored for erase.
- flash_dq_in  input  8  flash data bus read-back.
- seq_active  output  1  block owns the flash bus.
- seq_addr  output  27  flash address.
- seq_data  output  8  flash write data.
- seq_data_oe  output  1  drive seq_data onto the bus.
- seq_ce_n  output  1  flash chip enable, active low.
- seq_oe_n  output  1  flash output enable, active low.
- seq_we_n  output  1  flash write enable, active low.
- busy  output  1  command in progress.
- done  output  1  sticky success flag.
- fail  output  1  sticky failure flag (timeout or verify mismatch).

Behaviour:
- Reset (asynchronous, effective immediately, including mid-sequence):
  - State IDLE.
  - seq_active, busy, done, fail and seq_data_oe = 0.
  - seq_ce_n, seq_oe_n, seq_we_n = 1.
  - seq_addr = 0, seq_data = 0.
  - The flash may be left mid-command; software must re-issue the command.
- cmd_start is accepted only in IDLE. Pulses while busy=1 are ignored.
- On acceptance:
  - cmd_erase, cmd_addr and cmd_data are latched.
  - done and fail clear.
  - busy and seq_active rise on the same edge.
  - Step index = 0.
- Write sequences. Hi = latched cmd_addr[26:12].
  - Program, 4 writes: {Hi,UNLOCK_ADDR1}<-AA, {Hi,UNLOCK_ADDR2}<-55, {Hi,UNLOCK_ADDR1}<-A0, cmd_addr<-cmd_data.
  - Erase, 6 writes: AA, 55 and 80 as above, then AA, 55, then {Hi,12'h000}<-30.
- Each bus write takes 3 cycles, so program occupies 12 cycles and erase 18 before polling:
  - W_SETUP: addr/data valid, data_oe=1, ce_n=0, we_n=1, oe_n=1.
  - W_PULSE: we_n=0.
  - W_HOLD: we_n=1, addr/data unchanged.
  - After W_HOLD: if more writes remain, go to W_SETUP with the next step; otherwise go to POLL.
- POLL:
  - Bus state: data_oe=0, ce_n=0, oe_n=0, we_n=1, seq_addr = cmd_addr.
  - flash_dq_in is sampled every cycle. Expected DQ7 = cmd_data[7] for program, 1 for erase.
  - Timeout counter starts at 0 on POLL entry and increments each poll cycle.
  - Two consecutive samples with DQ7 == expected go to VERIFY.
  - A non-matching sample resets the match count to 0.
  - When the counter reaches PROG_TIMEOUT or ERASE_TIMEOUT, go to ABORT.
- VERIFY (one cycle, bus as in POLL):
  - Program: flash_dq_in == cmd_data → FIN_OK; mismatch → FIN_ERR.
  - Erase: flash_dq_in == FF → FIN_OK; otherwise → FIN_ERR.
- ABORT: one 3-cycle bus write of F0 to cmd_addr (reset command), then FIN_ERR.
- FIN_OK / FIN_ERR (one cycle):
  - All enables inactive.
  - seq_active=0 and busy=0 on exit to IDLE.
  - done=1 (OK) or fail=1 (ERR), held until the next accepted cmd_start or reset.
- seq_active deasserts no earlier than the cycle after the last flash strobe goes inactive. It is never high with all of ce_n/oe_n/we_n changing on the same edge as the bus release.
- Counter saturates at its timeout value; no wrap-around.

Test Plan:
- Program 0x1234567 <- 0x5A, flash model completes after 20 poll cycles:
  - Writes in order: 0x1234AAA<-AA, 0x1234555<-55, 0x1234AAA<-A0, 0x1234567<-5A, each with we_n low exactly 1 cycle.
  - done=1, fail=0, busy low.
- Sector erase, cmd_addr 0x0ABCDEF, completion after 500 cycles:
  - Six writes ending 0x0ABC000<-30.
  - Then read FF → done=1.
- Program where the model never returns DQ7 valid:
  - After 1024 poll cycles, one F0 write to cmd_addr, then fail=1 and done=0.
- Model reports DQ7 correct but byte 0x5B versus expected 0x5A → fail=1.
- cmd_start pulsed during W_PULSE of step 1: ignored; sequence and latched data unchanged.
- reset_n asserted during step 2 W_PULSE: same-instant we_n=1, seq_active=0, busy=0.
  - After release, a new cmd_start runs the full sequence from step 0.
